// File: rtl/line_pkg.sv
// Shared constants for the keyboard line editor and its echo/display stage.
package line_pkg;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam int LINE_BYTES = 16;

    // Line editor state encoding (2 bits)
    localparam logic [1:0] ST_EDIT   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

endpackage

// File: rtl/line_assembler_key_classify.sv
// Combinational ASCII key classifier; shared with the echo/display stage.
import line_pkg::*;

module key_classify (
    input  logic [7:0] key_ascii,
    output logic       is_print,
    output logic       is_bs,
    output logic       is_enter
);

    // Sort the code into the three classes the editor reacts to
    always_comb begin
        is_print = (key_ascii >= ASCII_PRINT_LO) && (key_ascii <= ASCII_PRINT_HI);
        is_bs    = (key_ascii == ASCII_BS);
        is_enter = (key_ascii == ASCII_CR);
    end

endmodule

// File: rtl/line_assembler.sv
// Collects key codes into a 16-byte line, hands it to playback on Enter,
// freezes it while playback runs and clears it once playback is done.
import line_pkg::*;

module line_assembler #(
    parameter int MAX_LEN = 15
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         key_valid,
    input  logic [7:0]   key_ascii,
    input  logic         do_loop,
    output logic [127:0] ipt_buf,
    output logic [3:0]   len,
    output logic         process_over,
    output logic         key_drop,
    output logic         busy
);

    localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

    logic                         is_print, is_bs, is_enter;
    logic                         key_hit;
    logic [1:0]                   state_q, state_d;
    logic [3:0]                   len_q, len_d;
    logic [LINE_BYTES-1:0][7:0]   buf_q, buf_d;
    logic                         drop_q, drop_d;

    key_classify u_classify (
        .key_ascii (key_ascii),
        .is_print  (is_print),
        .is_bs     (is_bs),
        .is_enter  (is_enter)
    );

    // A strobe of a class the editor acts on (others vanish silently)
    assign key_hit = key_valid && (is_print || is_bs || is_enter);

    // Next-state, buffer edit and drop decision
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        buf_d   = buf_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_EDIT: begin
                if (key_valid) begin
                    if (is_print) begin
                        if (len_q < MAX_LEN_C) begin
                            buf_d[len_q] = key_ascii;
                            len_d        = len_q + 4'd1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (is_bs) begin
                        if (len_q != 4'd0) begin
                            buf_d[len_q - 4'd1] = 8'h00;
                            len_d               = len_q - 4'd1;
                        end
                    end else if (is_enter) begin
                        // An empty line could never complete the do_loop
                        // handshake, so it is refused outright.
                        if (len_q != 4'd0) state_d = ST_COMMIT;
                        else               drop_d  = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                drop_d = key_hit;
                if (do_loop) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                drop_d = key_hit;
                if (!do_loop) state_d = ST_CLEAR;
            end
            default: begin
                drop_d  = key_hit;
                buf_d   = '0;
                len_d   = 4'd0;
                state_d = ST_EDIT;
            end
        endcase
    end

    // State, line buffer and drop pulse registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_EDIT;
            len_q   <= 4'd0;
            buf_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    assign ipt_buf      = buf_q;
    assign len          = len_q;
    assign process_over = (state_q == ST_COMMIT);
    assign busy         = (state_q != ST_EDIT);
    assign key_drop     = drop_q;

endmodule

// File: tb/tb_line_assembler.sv
// Self-checking bench for line_assembler: vector table, directed corner
// sequences and randomized keys against a queue-based line model.
module tb_line_assembler;

    logic         clk;
    logic         clrn;
    logic         key_valid;
    logic [7:0]   key_ascii;
    logic         do_loop;
    logic [127:0] ipt_buf;
    logic [3:0]   len;
    logic         process_over;
    logic         key_drop;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    line_assembler #(.MAX_LEN(15)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .key_valid    (key_valid),
        .key_ascii    (key_ascii),
        .do_loop      (do_loop),
        .ipt_buf      (ipt_buf),
        .len          (len),
        .process_over (process_over),
        .key_drop     (key_drop),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // store_char stand-in: raises do_loop on the negedge it sees process_over,
    // plays len characters, then drops it. Can be overridden with a fixed level.
    logic sc_auto  = 1'b1;
    logic sc_force = 1'b0;
    logic sc_run   = 1'b0;
    int   sc_cnt   = 0;
    initial do_loop = 1'b0;
    always @(negedge clk) begin
        if (!sc_auto) begin
            do_loop <= sc_force;
            sc_run  <= 1'b0;
        end else if (!sc_run) begin
            if (process_over) begin
                do_loop <= 1'b1;
                sc_run  <= 1'b1;
                sc_cnt  <= int'(len);
            end
        end else if (sc_cnt <= 1) begin
            do_loop <= 1'b0;
            sc_run  <= 1'b0;
        end else begin
            sc_cnt <= sc_cnt - 1;
        end
    end

    // Reference model: the line is a byte queue; mode 0 edit, 1 waiting for
    // playback start, 2 playing, 3 one clearing cycle.
    logic [7:0] m_line[$];
    int         m_mode;
    logic       m_drop;

    function automatic logic [127:0] m_buf();
        logic [127:0] r = '0;
        for (int i = 0; i < m_line.size(); i++) r[8*i +: 8] = m_line[i];
        return r;
    endfunction

    task automatic m_reset();
        m_line.delete();
        m_mode = 0;
        m_drop = 1'b0;
    endtask

    task automatic m_step(input logic v, input logic [7:0] a, input logic dl);
        logic pr, bs, en;
        pr = (a >= 8'h20) && (a <= 8'h7E);
        bs = (a == 8'h08);
        en = (a == 8'h0D);
        m_drop = 1'b0;
        if (m_mode == 0) begin
            if (v && pr) begin
                if (m_line.size() < 15) m_line.push_back(a);
                else m_drop = 1'b1;
            end else if (v && bs) begin
                if (m_line.size() > 0) void'(m_line.pop_back());
            end else if (v && en) begin
                if (m_line.size() > 0) m_mode = 1;
                else m_drop = 1'b1;
            end
        end else begin
            m_drop = v && (pr || bs || en);
            if (m_mode == 1)      begin if (dl)  m_mode = 2; end
            else if (m_mode == 2) begin if (!dl) m_mode = 3; end
            else begin
                m_line.delete();
                m_mode = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_buf",  ipt_buf, m_buf());
        chk("m_len",  128'(len), 128'(m_line.size()));
        chk("m_po",   128'(process_over), 128'(m_mode == 1));
        chk("m_busy", 128'(busy), 128'(m_mode != 0));
        chk("m_drop", 128'(key_drop), 128'(m_drop));
    endtask

    // One clock: drive after negedge, step model at posedge, compare 1 after.
    task automatic tick(input logic v, input logic [7:0] a);
        @(negedge clk);
        key_valid = v;
        key_ascii = a;
        @(posedge clk);
        m_step(v, a, do_loop);
        #1;
        chk_model();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic assert_reset();
        clrn = 1'b0;
        key_valid = 1'b0;
        #1;
        chk("rst_buf",  ipt_buf, '0);
        chk("rst_flag", 128'({len, process_over, key_drop, busy}), '0);
        m_reset();
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  a;
        logic [3:0]  len;
        logic        drop;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[13];

    int po_cnt;
    int drops;
    logic done;
    logic [127:0] saved;

    initial begin
        vecs[0]  = '{1'b1, 8'h48, 4'd1, 1'b0, 32'h0000_0048};
        vecs[1]  = '{1'b1, 8'h49, 4'd2, 1'b0, 32'h0000_4948};
        vecs[2]  = '{1'b1, 8'h08, 4'd1, 1'b0, 32'h0000_0048};
        vecs[3]  = '{1'b1, 8'h08, 4'd0, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b1, 8'h08, 4'd0, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b1, 8'h01, 4'd0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b1, 8'h41, 4'd1, 1'b0, 32'h0000_0041};
        vecs[7]  = '{1'b1, 8'h42, 4'd2, 1'b0, 32'h0000_4241};
        vecs[8]  = '{1'b1, 8'h43, 4'd3, 1'b0, 32'h0043_4241};
        vecs[9]  = '{1'b1, 8'h08, 4'd2, 1'b0, 32'h0000_4241};
        vecs[10] = '{1'b1, 8'h44, 4'd3, 1'b0, 32'h0044_4241};
        vecs[11] = '{1'b0, 8'h5A, 4'd3, 1'b0, 32'h0044_4241};
        vecs[12] = '{1'b1, 8'h7F, 4'd3, 1'b0, 32'h0044_4241};

        clrn = 1'b0;
        key_valid = 1'b0;
        key_ascii = 8'h00;
        m_reset();
        assert_reset();

        // "HI", backspaces, ignored codes, "ABC" BS "D"
        tick(1'b1, 8'h48);
        tick(1'b1, 8'h49);
        chk("hi_lo16", 128'(ipt_buf[15:0]), 128'(16'h4948));
        chk("hi_busy", 128'(busy), '0);
        assert_reset();
        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].v, vecs[i].a);
            chk($sformatf("vec%0d_len", i), 128'(len), 128'(vecs[i].len));
            chk($sformatf("vec%0d_drop", i), 128'(key_drop), 128'(vecs[i].drop));
            chk($sformatf("vec%0d_buf", i), ipt_buf, 128'(vecs[i].lo));
        end

        // Commit held without do_loop, then async reset in COMMIT with len 5
        assert_reset();
        sc_auto = 1'b0;
        sc_force = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h61 + 8'(i));
        tick(1'b1, 8'h0D);
        chk("hold_po0", 128'(process_over), 128'(1));
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00);
            chk("hold_po", 128'(process_over), 128'(1));
            chk("hold_len", 128'(len), 128'(5));
        end
        assert_reset();
        sc_auto = 1'b1;
        tick(1'b1, 8'h51);
        chk("post_rst_b0", ipt_buf, 128'(8'h51));

        // Enter with len 3, key during PLAY, full handshake and clear
        assert_reset();
        tick(1'b1, 8'h78);
        tick(1'b1, 8'h79);
        tick(1'b1, 8'h7A);
        saved = ipt_buf;
        tick(1'b1, 8'h0D);
        chk("enter_po", 128'(process_over), 128'(1));
        chk("enter_buf", ipt_buf, saved);
        po_cnt = 1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (i == 1) begin
                tick(1'b1, 8'h58);
                chk("play_drop", 128'(key_drop), 128'(1));
            end else begin
                tick(1'b0, 8'h00);
            end
            if (process_over) po_cnt++;
            if (do_loop) begin
                chk("play_buf", ipt_buf, saved);
                chk("play_len", 128'(len), 128'(3));
            end
            if (!busy) done = 1'b1;
        end
        chk("play_done", 128'(done), 128'(1));
        chk("po_cycles", 128'(po_cnt), 128'(1));
        chk("clr_len", 128'(len), '0);
        chk("clr_buf", ipt_buf, '0);

        // Enter on empty line
        tick(1'b1, 8'h0D);
        chk("empty_po", 128'(process_over), '0);
        chk("empty_drop", 128'(key_drop), 128'(1));

        // 16 printable keys: 15 land, one drop
        tick(1'b0, 8'h00);
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 8'h61 + 8'(i));
            if (key_drop) drops++;
        end
        tick(1'b0, 8'h00);
        if (key_drop) drops++;
        chk("full_len", 128'(len), 128'(15));
        chk("full_b14", 128'(ipt_buf[119:112]), 128'(8'h6F));
        chk("full_b15", 128'(ipt_buf[127:120]), '0);
        chk("full_drops", 128'(drops), 128'(1));

        // Randomized keys against the model
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] a;
            r = $urandom_range(99);
            if (r < 55)      a = 8'($urandom_range(32, 126));
            else if (r < 72) a = 8'h08;
            else if (r < 80) a = 8'h0D;
            else if (r < 88) a = 8'($urandom_range(127, 255));
            else             a = 8'($urandom_range(0, 31));
            tick(r < 93, a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_assembler.md
# line_assembler

Keyboard-side line editor that collects ASCII key codes into a 16-byte line buffer, handles backspace, and on Enter hands the finished line to the character playback stage (`store_char`) through its `ipt_buf`/`len`/`process_over` inputs. It sits between the PS/2 scan-code-to-ASCII decoder and `store_char`. It freezes the buffer while playback runs and clears it when playback ends.

## Interface
- `MAX_LEN`, default 15: maximum characters per line. Fixed at 15 because `len` is 4 bits.
- `clk` input 1: system clock; all state changes on posedge.
- `clrn` input 1: asynchronous, active-low reset.
- `key_valid` input 1: one-cycle strobe; `key_ascii` is valid this cycle.
- `key_ascii` input 8: ASCII code from the decoder.
- `do_loop` input 1: playback-busy level from `store_char`. It changes on negedge; this block samples it on posedge only.
- `ipt_buf` output 128: line buffer. Char k sits in bits [8k+7:8k], char 0 in [7:0]. Unused bytes are 0x00.
- `len` output 4: number of valid characters, 0..15.
- `process_over` output 1: commit request level toward playback.
- `key_drop` output 1: one-cycle pulse when an accepted-class key is discarded.
- `busy` output 1: high whenever state is not EDIT.

## Operation
- Key classes:
  - printable: 0x20..0x7E
  - BS: 0x08
  - ENTER: 0x0D
  - all other codes are ignored silently, with no `key_drop`.
- States: EDIT, COMMIT, PLAY, CLEAR.
- EDIT:
  - printable with `len` < 15: write to byte[`len`], `len`+1.
  - printable with `len` == 15: discard, pulse `key_drop`.
  - BS with `len` > 0: byte[`len`-1] := 0x00, `len`-1.
  - BS with `len` == 0: no effect, no `key_drop`.
  - ENTER with `len` > 0: go to COMMIT; the ENTER code itself is not stored.
  - ENTER with `len` == 0: ignored and pulses `key_drop`. An empty line would make `store_char` raise and drop `do_loop` inside one negedge, so a handshake could never be seen.
- COMMIT:
  - `process_over` = 1.
  - `ipt_buf`/`len` are frozen.
  - Stay in COMMIT until `do_loop` is sampled 1, then go to PLAY.
- PLAY:
  - `process_over` = 0; buffer stays frozen.
  - When `do_loop` is sampled 0, go to CLEAR.
- CLEAR: `ipt_buf` := 0, `len` := 0, then go to EDIT. This state lasts one cycle.
- In COMMIT, PLAY and CLEAR, every printable/BS/ENTER strobe is discarded and pulses `key_drop`.
- `key_drop` is registered and is high in the cycle after the offending strobe.
- Reset mid-operation:
  - forces EDIT, `ipt_buf` = 0, `len` = 0, `process_over` = 0, `key_drop` = 0.
  - A playback already started downstream keeps running.
  - This block does not wait for `do_loop` after reset.

## Timing
- Reset values: all outputs 0; state EDIT.
- Key-to-buffer latency: `key_ascii` strobed in cycle N appears in `ipt_buf`/`len` after posedge N+1.
- ENTER in cycle N: `process_over` = 1 from posedge N+1.
- Rising `process_over` is observed by `store_char` at the following negedge, so `do_loop` reads 1 at the next posedge.
  - Typical COMMIT duration is therefore 1 cycle.
  - `process_over` is nonetheless held until `do_loop` = 1 is actually sampled.
- `len` is stable for the full duration of `do_loop` = 1, because `store_char` compares its index against `len` live.
- EDIT re-entry: 1 cycle after `do_loop` falls; keys are accepted again from that cycle.
- Back-to-back strobes (`key_valid` every cycle) are all processed in EDIT; each takes effect one cycle apart.
- `key_valid` coinciding with a state transition is judged by the state in which it is sampled. For example, a strobe in the last PLAY cycle is dropped.

## Structure
- Shared package `line_pkg`:
  - `ASCII_BS` = 8'h08
  - `ASCII_CR` = 8'h0D
  - `ASCII_PRINT_LO` = 8'h20
  - `ASCII_PRINT_HI` = 8'h7E
  - state encoding: EDIT/COMMIT/PLAY/CLEAR, 2 bits
  - `LINE_BYTES` = 16
- One sub-module is natural: `key_classify`. It is combinational, takes `key_ascii` and produces `is_print`/`is_bs`/`is_enter`. It is reused by the echo/display stage.
- Top level holds the FSM, a 4-bit length counter and a 16×8 register file flattened onto `ipt_buf`.

## Test plan
- Reset, then type "HI" (0x48, 0x49) -> `ipt_buf`[15:0] = 16'h4948, `len` = 2, `busy` = 0, other bytes 0.
- Type "ABC", BS, "D" -> bytes = 41 42 44, byte3 = 00, `len` = 3.
- Type 16 printable keys -> `len` = 15, byte14 = 16th-minus-one key, byte15 = 00, exactly one `key_drop` pulse.
- ENTER with `len` = 3, model `store_char` negedge behaviour -> `process_over` high 1 cycle; `ipt_buf` stable while `do_loop` = 1; after `do_loop` falls, `len` = 0 and `ipt_buf` = 0 one cycle later.
- Type 'X' during PLAY -> `key_drop` pulse, buffer unchanged. ENTER on empty line -> no `process_over`, `key_drop` pulse.
- Assert `clrn` low while in COMMIT with `len` = 5 -> all outputs 0 immediately (asynchronous); after release, state EDIT and the first key lands in byte0.
